// File: rtl/icc_branch_unit_if.sv
// icc/Bicc unit bus: EX-stage ALU flags and branch fields in,
// condition codes, branch decision and squash/trap status out.
interface icc_branch_unit_if;
  logic       Stall;
  logic       Valid;
  logic [5:0] Op3;
  logic       N;
  logic       Z;
  logic       V;
  logic       C;
  logic       IsBicc;
  logic [3:0] Cond;
  logic       ABit;
  logic [3:0] Icc;
  logic       CinOut;
  logic       Taken;
  logic       SquashSlot;
  logic       TrapReq;

  modport master (
    output Stall, Valid, Op3, N, Z, V, C,
    output IsBicc, Cond, ABit,
    input  Icc, CinOut, Taken, SquashSlot, TrapReq
  );

  modport slave (
    input  Stall, Valid, Op3, N, Z, V, C,
    input  IsBicc, Cond, ABit,
    output Icc, CinOut, Taken, SquashSlot, TrapReq
  );
endinterface

// File: rtl/icc_branch_unit.sv
// icc register, Bicc evaluator and delay-slot/annul sequencer.
// Optional Ticc trap request: define SPARC_TICC_EN.
module icc_branch_unit #(
  parameter logic [3:0] ICC_RST  = 4'b0000,
  parameter int         SLOT_LEN = 1
) (
  input logic           Clk,
  input logic           Clr,
  icc_branch_unit_if.slave bus
);

  typedef enum logic {
    RUN,
    SLOT
  } state_t;

  if (SLOT_LEN != 1) begin : g_bad_slot
    $error("icc_branch_unit: only SLOT_LEN=1 is supported");
  end

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_squash;
  logic       w_squash_nxt;
  logic [3:0] r_icc;
  logic       w_eff;
  logic       w_cc_op;
  logic       w_cond;
  logic       w_br;
  logic       w_taken;
  logic       w_ann;

  function automatic logic f_cond(
    input logic [3:0] icc,
    input logic [3:0] cd
  );
    logic n, z, v, c, r;
    {n, z, v, c} = icc;
    case (cd[2:0])
      3'd0:    r = 1'b0;
      3'd1:    r = z;
      3'd2:    r = z | (n ^ v);
      3'd3:    r = n ^ v;
      3'd4:    r = c | z;
      3'd5:    r = c;
      3'd6:    r = n;
      default: r = v;
    endcase
    return r ^ cd[3];
  endfunction

  assign w_eff   = Clr & bus.Valid & ~bus.Stall & ~r_squash;
  assign w_cc_op = (bus.Op3[5:4] == 2'b01);
  assign w_cond  = f_cond(r_icc, bus.Cond);
  assign w_br    = w_eff & bus.IsBicc;
  assign w_taken = w_br & w_cond;
  assign w_ann   = w_br & bus.ABit &
                   (~w_taken | (bus.Cond == 4'b1000));

`ifdef SPARC_TICC_EN
  logic r_trap;
  logic w_trap;

  assign w_trap = Clr & ~bus.Stall & bus.Valid &
                  (bus.Op3 == 6'b111010) & ~r_squash & w_cond;

  // One-cycle trap request pulse following a true Ticc
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) r_trap <= 1'b0;
    else      r_trap <= w_trap;
  end

  assign bus.TrapReq = r_trap;
`else
  logic w_unused_op3;
  assign w_unused_op3 = ^bus.Op3[3:0];
  assign bus.TrapReq  = 1'b0;
`endif

  // Condition codes latch ALU flags from effective cc ops
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr)                 r_icc <= ICC_RST;
    else if (w_eff & w_cc_op) r_icc <= {bus.N, bus.Z, bus.V, bus.C};
  end

  // Delay-slot state and pending squash
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      r_state  <= RUN;
      r_squash <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_squash <= w_squash_nxt;
    end
  end

  // Next delay-slot state; a stall holds everything
  always_comb begin
    w_state_nxt  = r_state;
    w_squash_nxt = r_squash;
    if (!bus.Stall) begin
      unique case (r_state)
        RUN: begin
          if (w_br) begin
            w_state_nxt  = SLOT;
            w_squash_nxt = w_ann;
          end
        end
        SLOT: begin
          if (w_br) begin
            w_state_nxt  = SLOT;
            w_squash_nxt = w_ann;
          end else begin
            w_state_nxt  = RUN;
            w_squash_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt  = RUN;
          w_squash_nxt = 1'b0;
        end
      endcase
`ifdef SPARC_TICC_EN
      if (w_trap) begin
        w_state_nxt  = RUN;
        w_squash_nxt = 1'b0;
      end
`endif
    end
  end

  assign bus.Icc        = r_icc;
  assign bus.CinOut     = r_icc[0];
  assign bus.Taken      = w_taken;
  assign bus.SquashSlot = r_squash;

endmodule

// File: tb/tb_icc_branch_unit.sv
// Directed-vector bench for icc_branch_unit with a
// queue scoreboard checked by an independent monitor.
module tb_icc_branch_unit;

  typedef struct {
    int         row;
    logic [3:0] icc;
    logic       taken;
    logic       sq;
    logic       trap;
  } exp_t;

  logic Clk;
  logic Clr;
  int   n_run;
  int   n_fail;
  int   row;
  exp_t q[$];

  icc_branch_unit_if bus ();

  icc_branch_unit #(
    .ICC_RST  (4'b0000),
    .SLOT_LEN (1)
  ) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input int r,
                     input logic [3:0] act, input logic [3:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s row %0d: got %b, expected %b", nm, r, act, req);
    end
  endtask

  // Monitor: DUT outputs are presented every cycle; compare mid-cycle
  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("icc",    e.row, bus.Icc, e.icc);
      chk("cinout", e.row, {3'b0, bus.CinOut}, {3'b0, e.icc[0]});
      chk("taken",  e.row, {3'b0, bus.Taken}, {3'b0, e.taken});
      chk("squash", e.row, {3'b0, bus.SquashSlot}, {3'b0, e.sq});
      chk("trap",   e.row, {3'b0, bus.TrapReq}, {3'b0, e.trap});
    end
  end

  task automatic v(
    input logic       clr, input logic st, input logic va,
    input logic [5:0] op,  input logic [3:0] nzvc,
    input logic       ib,  input logic [3:0] cd, input logic ab,
    input logic [3:0] e_icc, input logic e_t, input logic e_sq
  );
    exp_t e;
    @(posedge Clk);
    #1;
    Clr        = clr;
    bus.Stall  = st;
    bus.Valid  = va;
    bus.Op3    = op;
    {bus.N, bus.Z, bus.V, bus.C} = nzvc;
    bus.IsBicc = ib;
    bus.Cond   = cd;
    bus.ABit   = ab;
    e.row   = row;
    e.icc   = e_icc;
    e.taken = e_t;
    e.sq    = e_sq;
    e.trap  = 1'b0;
    q.push_back(e);
    row++;
  endtask

  localparam logic [5:0] ADD = 6'b010000;
  localparam logic [5:0] SUB = 6'b010100;
  localparam logic [5:0] NOP = 6'b000000;
  localparam logic [5:0] TCC = 6'b111010;

  initial begin
    n_run = 0;
    n_fail = 0;
    row = 0;
    Clr = 1'b0;
    bus.Stall = 1'b0;
    bus.Valid = 1'b0;
    bus.Op3 = NOP;
    {bus.N, bus.Z, bus.V, bus.C} = 4'b0;
    bus.IsBicc = 1'b0;
    bus.Cond = 4'b0;
    bus.ABit = 1'b0;
    // clr st va op nzvc ib cd ab | icc t sq
    v(0,0,1,NOP,4'b0000,1,4'b1000,0, 4'b0000,0,0);
    v(1,0,1,ADD,4'b1011,0,4'b0000,0, 4'b0000,0,0);
    v(1,0,0,NOP,4'b0000,0,4'b0000,0, 4'b1011,0,0);
    v(1,0,1,SUB,4'b0100,0,4'b0000,0, 4'b1011,0,0);
    v(1,0,0,NOP,4'b0000,0,4'b0000,0, 4'b0100,0,0);
    v(1,0,1,NOP,4'b0000,1,4'b0001,0, 4'b0100,1,0);
    v(1,0,1,NOP,4'b0000,1,4'b1001,0, 4'b0100,0,0);
    v(1,0,1,NOP,4'b0000,1,4'b0000,0, 4'b0100,0,0);
    v(1,0,0,NOP,4'b0000,0,4'b0000,0, 4'b0100,0,0);
    v(1,0,1,ADD,4'b1000,0,4'b0000,0, 4'b0100,0,0);
    v(1,0,0,NOP,4'b0000,0,4'b0000,0, 4'b1000,0,0);
    v(1,0,1,NOP,4'b0000,1,4'b0011,1, 4'b1000,1,0);
    v(1,0,1,ADD,4'b0001,0,4'b0000,0, 4'b1000,0,0);
    v(1,0,0,NOP,4'b0000,0,4'b0000,0, 4'b0001,0,0);
    v(1,0,1,NOP,4'b0000,1,4'b1000,1, 4'b0001,1,0);
    v(1,0,1,SUB,4'b0100,0,4'b0000,0, 4'b0001,0,1);
    v(1,0,0,NOP,4'b0000,0,4'b0000,0, 4'b0001,0,0);
    v(1,0,1,ADD,4'b0110,0,4'b0000,0, 4'b0001,0,0);
    v(1,0,1,NOP,4'b0000,1,4'b1001,1, 4'b0110,0,0);
    v(1,1,1,NOP,4'b0000,1,4'b1000,0, 4'b0110,0,1);
    v(1,1,1,NOP,4'b0000,1,4'b1000,0, 4'b0110,0,1);
    v(1,1,1,NOP,4'b0000,1,4'b1000,0, 4'b0110,0,1);
    v(1,0,1,NOP,4'b0000,1,4'b1000,0, 4'b0110,0,1);
    v(1,0,0,NOP,4'b0000,0,4'b0000,0, 4'b0110,0,0);
    v(1,1,1,ADD,4'b1111,0,4'b0000,0, 4'b0110,0,0);
    v(1,0,0,NOP,4'b0000,0,4'b0000,0, 4'b0110,0,0);
    v(1,1,1,NOP,4'b0000,1,4'b1000,0, 4'b0110,0,0);
    v(1,0,0,NOP,4'b0000,0,4'b0000,0, 4'b0110,0,0);
    v(1,0,1,TCC,4'b1111,0,4'b1000,0, 4'b0110,0,0);
    v(1,0,1,NOP,4'b1111,0,4'b0000,0, 4'b0110,0,0);
    v(1,0,0,NOP,4'b0000,0,4'b0000,0, 4'b0110,0,0);
    v(1,0,1,NOP,4'b0000,1,4'b0010,0, 4'b0110,1,0);
    v(1,0,1,NOP,4'b0000,1,4'b1010,0, 4'b0110,0,0);
    v(1,0,1,NOP,4'b0000,1,4'b0100,0, 4'b0110,1,0);
    v(1,0,1,NOP,4'b0000,1,4'b0111,0, 4'b0110,1,0);
    v(1,0,1,NOP,4'b0000,1,4'b1111,0, 4'b0110,0,0);
    v(1,0,1,NOP,4'b0000,1,4'b1110,0, 4'b0110,1,0);
    v(1,0,1,NOP,4'b0000,1,4'b0101,0, 4'b0110,0,0);
    v(1,0,0,NOP,4'b0000,0,4'b0000,0, 4'b0110,0,0);
    v(1,0,1,NOP,4'b0000,1,4'b1000,1, 4'b0110,1,0);
    v(1,1,0,NOP,4'b0000,0,4'b0000,0, 4'b0110,0,1);
    v(1,1,0,NOP,4'b0000,0,4'b0000,0, 4'b0110,0,1);
    v(0,1,0,NOP,4'b0000,0,4'b0000,0, 4'b0000,0,0);
    v(1,0,0,NOP,4'b0000,0,4'b0000,0, 4'b0000,0,0);
    v(1,0,1,NOP,4'b0000,1,4'b0000,1, 4'b0000,0,0);
    v(1,0,0,NOP,4'b0000,0,4'b0000,0, 4'b0000,0,1);
    v(1,0,0,NOP,4'b0000,0,4'b0000,0, 4'b0000,0,0);
    repeat (3) @(posedge Clk);
    if (q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
